// File: rtl/direct_cache_controller_pkg.sv
// Shared definitions for the direct-mapped cache controller: default widths
// and the controller state encoding.
package direct_cache_controller_pkg;

  localparam int DefaultWidth             = 8;
  localparam int DefaultAddressWidth      = 8;
  localparam int DefaultCacheAddressWidth = 4;
  localparam int DefaultCountWidth        = 16;

  // Controller states; the numeric values are part of the external contract.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    MEM_READ  = 3'd2,
    MEM_WRITE = 3'd3,
    FILL      = 3'd4,
    RESPOND   = 3'd5
  } state_t;

  // True for the states that own the memory request handshake.
  function automatic logic is_mem_state(state_t s);
    return (s == MEM_READ) || (s == MEM_WRITE);
  endfunction

endpackage

// File: rtl/direct_cache_controller_sat_counter.sv
// Saturating up-counter: increments by one on inc and sticks at all-ones.
module sat_counter
  import direct_cache_controller_pkg::*;
#(
  parameter int Width = DefaultCountWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_reg;

  // Count up on inc, but never wrap past the all-ones value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {Width{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/direct_cache_controller.sv
// Direct-mapped cache sequencer between one CPU requester and a slow memory.
// Reads look up the cache and fill on a miss; writes go through to memory and
// allocate the line. Read hits and misses are counted with saturation.
module direct_cache_controller
  import direct_cache_controller_pkg::*;
#(
  parameter int Width             = DefaultWidth,
  parameter int AddressWidth      = DefaultAddressWidth,
  parameter int CacheAddressWidth = DefaultCacheAddressWidth,
  parameter int CountWidth        = DefaultCountWidth
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [AddressWidth-1:0] cpu_addr,
  input  logic [Width-1:0]        cpu_wdata,
  output logic                    cpu_busy,
  output logic                    cpu_ready,
  output logic [Width-1:0]        cpu_rdata,
  output logic [AddressWidth-1:0] cache_raddr,
  input  logic                    cache_hit,
  input  logic [Width-1:0]        cache_Q,
  output logic                    cache_we,
  output logic [AddressWidth-1:0] cache_waddr,
  output logic [Width-1:0]        cache_D,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [AddressWidth-1:0] mem_addr,
  output logic [Width-1:0]        mem_wdata,
  input  logic                    mem_ack,
  input  logic [Width-1:0]        mem_rdata,
  output logic [CountWidth-1:0]   hit_count,
  output logic [CountWidth-1:0]   miss_count
);

  // The index must fit inside the address; a misconfigured instance simply
  // never leaves IDLE instead of corrupting the cache.
  localparam bit CfgOk = (CacheAddressWidth > 0) && (CacheAddressWidth <= AddressWidth);

  state_t                  state_reg, state_next;
  logic [AddressWidth-1:0] addr_reg;
  logic [Width-1:0]        data_reg;
  logic [Width-1:0]        rdata_reg;
  logic                    accept;
  logic                    hit_inc;
  logic                    miss_inc;
  logic [1:0]              cnt_inc;
  logic [CountWidth-1:0]   cnt_val [2];

  assign accept = cpu_req && CfgOk;

  // State register; reset abandons any in-flight transaction at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and state-decoded strobes (glitch-free, no data path).
  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    cache_we   = 1'b0;
    cpu_ready  = 1'b0;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = cpu_we ? MEM_WRITE : LOOKUP;
        end
      end
      LOOKUP: begin
        if (cache_hit) begin
          hit_inc    = 1'b1;
          state_next = RESPOND;
        end else begin
          miss_inc   = 1'b1;
          state_next = MEM_READ;
        end
      end
      MEM_READ, MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = (state_reg == MEM_WRITE);
        if (mem_ack) begin
          state_next = FILL;
        end
      end
      FILL: begin
        cache_we   = 1'b1;
        state_next = RESPOND;
      end
      RESPOND: begin
        cpu_ready  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latch and data capture; cpu_rdata only changes on read completion paths.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg  <= '0;
      data_reg  <= '0;
      rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            addr_reg <= cpu_addr;
            data_reg <= cpu_wdata;
          end
        end
        LOOKUP: begin
          if (cache_hit) begin
            rdata_reg <= cache_Q;
          end
        end
        MEM_READ: begin
          if (mem_ack) begin
            data_reg  <= mem_rdata;
            rdata_reg <= mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cpu_busy    = (state_reg != IDLE);
  assign cpu_rdata   = rdata_reg;
  assign cache_raddr = addr_reg;
  assign cache_waddr = addr_reg;
  assign cache_D     = data_reg;
  assign mem_addr    = addr_reg;
  assign mem_wdata   = data_reg;

  // Hit counter at index 0, miss counter at index 1.
  assign cnt_inc = {miss_inc, hit_inc};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(
        .Width(CountWidth)
      ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (cnt_inc[gi]),
        .count(cnt_val[gi])
      );
    end
  endgenerate

  assign hit_count  = cnt_val[0];
  assign miss_count = cnt_val[1];

endmodule

// File: tb/tb_direct_cache_controller.sv
// Self-checking bench for direct_cache_controller: directed scenarios followed
// by random traffic, compared against a transaction-level reference model.
module tb_direct_cache_controller;

  localparam int CW     = 2;
  localparam int CntMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [7:0]    cpu_addr = 8'h00;
  logic [7:0]    cpu_wdata = 8'h00;
  logic          cpu_busy, cpu_ready;
  logic [7:0]    cpu_rdata;
  logic [7:0]    cache_raddr, cache_waddr, cache_D;
  logic          cache_hit, cache_we;
  logic [7:0]    cache_Q;
  logic          mem_req, mem_we;
  logic [7:0]    mem_addr, mem_wdata;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_rdata = 8'h00;
  logic [CW-1:0] hit_count, miss_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  always #5 clk = ~clk;

  direct_cache_controller #(
    .Width(8), .AddressWidth(8), .CacheAddressWidth(4), .CountWidth(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .cache_raddr(cache_raddr), .cache_hit(cache_hit), .cache_Q(cache_Q),
    .cache_we(cache_we), .cache_waddr(cache_waddr), .cache_D(cache_D),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // ---------------- environment: cache storage (16 lines, full-address tag)
  logic [7:0] c_line [16];
  logic       c_valid[16];
  logic [7:0] c_data [16];

  always_comb begin
    cache_hit = c_valid[cache_raddr[3:0]] && (c_line[cache_raddr[3:0]] == cache_raddr);
    cache_Q   = c_data[cache_raddr[3:0]];
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) c_valid[i] <= 1'b0;
    end else if (cache_we) begin
      c_valid[cache_waddr[3:0]] <= 1'b1;
      c_line[cache_waddr[3:0]]  <= cache_waddr;
      c_data[cache_waddr[3:0]]  <= cache_D;
    end
  end

  // ---------------- environment: slow memory acking ack_delay cycles after mem_req rises
  logic [7:0] env_mem[256];
  int         ack_delay = 0;
  int         wait_cnt  = 0;

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (rst && mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = env_mem[mem_addr];
        if (mem_we) env_mem[mem_addr] = mem_wdata;
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // ---------------- reference model: memory image, line ownership, counters
  logic [7:0] ref_mem [256];
  logic [7:0] ref_line[16];
  bit         ref_valid[16];
  int         ref_hits, ref_misses;
  logic [7:0] ref_rdata;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    ref_hits   = 0;
    ref_misses = 0;
    ref_rdata  = 8'h00;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  {31'd0, cpu_busy},  32'd0);
    check({tag, "_mreq"},  {31'd0, mem_req},   32'd0);
    check({tag, "_cwe"},   {31'd0, cache_we},  32'd0);
    check({tag, "_ready"}, {31'd0, cpu_ready}, 32'd0);
    check({tag, "_hits"},  32'(hit_count),     32'd0);
    check({tag, "_miss"},  32'(miss_count),    32'd0);
    check({tag, "_rdata"}, 32'(cpu_rdata),     32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;
  endtask

  // One CPU transaction. Latency is counted inclusively from the request
  // cycle: hit 3, read miss 5+k, write 4+k cycles.
  task automatic do_txn(input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                        input int k, input bit inject);
    int         idx, exp_lat, exp_mreq, exp_cw;
    bit         hit, injected;
    logic [7:0] exp_d;
    int         mreq_n, mem_bad, cw_n, ready_cnt, ready_n, inj_n;
    logic [7:0] cw_addr, cw_d, rd;

    idx      = int'(addr[3:0]);
    hit      = !we && ref_valid[idx] && (ref_line[idx] == addr);
    exp_lat  = we ? 4 + k : (hit ? 3 : 5 + k);
    exp_mreq = hit ? 0 : k + 1;
    exp_cw   = hit ? 0 : 1;
    exp_d    = we ? wdata : ref_mem[addr];

    if (we) begin
      ref_mem[addr]  = wdata;
      ref_line[idx]  = addr;
      ref_valid[idx] = 1'b1;
    end else begin
      if (hit) begin
        if (ref_hits < CntMax) ref_hits++;
      end else begin
        if (ref_misses < CntMax) ref_misses++;
        ref_line[idx]  = addr;
        ref_valid[idx] = 1'b1;
      end
      ref_rdata = ref_mem[addr];
    end

    mreq_n = 0; mem_bad = 0; cw_n = 0; ready_cnt = 0; ready_n = 0; inj_n = 0;
    injected = 1'b0; cw_addr = 8'h00; cw_d = 8'h00; rd = 8'h00;

    @(negedge clk);
    ack_delay = k;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;

    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 1) cpu_req = 1'b0;
      if (injected && n == inj_n + 1) cpu_req = 1'b0;
      if (inject && !injected && mem_req) begin
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 8'h01;
        injected = 1'b1;
        inj_n    = n;
      end
      if (mem_req) begin
        mreq_n++;
        if (mem_we !== we || mem_addr !== addr || (we && mem_wdata !== wdata)) mem_bad++;
      end
      if (cache_we) begin
        cw_n++;
        cw_addr = cache_waddr;
        cw_d    = cache_D;
      end
      if (cpu_ready) begin
        ready_cnt++;
        if (ready_cnt == 1) begin
          ready_n = n;
          rd      = cpu_rdata;
        end
      end
      if (ready_cnt > 0 && n >= ready_n + 2) break;
    end
    cpu_req = 1'b0;

    check("ready_count", 32'(ready_cnt), 32'd1);
    check("latency", (ready_cnt > 0) ? 32'(ready_n + 1) : 32'd0, 32'(exp_lat));
    check("mem_req_cycles", 32'(mreq_n), 32'(exp_mreq));
    check("mem_signals_bad", 32'(mem_bad), 32'd0);
    check("cache_we_pulses", 32'(cw_n), 32'(exp_cw));
    if (exp_cw == 1) begin
      check("cache_waddr", 32'(cw_addr), 32'(addr));
      check("cache_D", 32'(cw_d), 32'(exp_d));
    end
    if (!we) check("rdata_at_ready", 32'(rd), 32'(ref_rdata));
    check("cpu_rdata_held", 32'(cpu_rdata), 32'(ref_rdata));
    check("hit_count", 32'(hit_count), 32'(ref_hits));
    check("miss_count", 32'(miss_count), 32'(ref_misses));
    check("busy_after", {31'd0, cpu_busy}, 32'd0);

    n_txn++;
    $display("txn %0d: %s addr=0x%02h wdata=0x%02h k=%0d hit=%0d lat=%0d rdata=0x%02h hits=%0d misses=%0d",
             n_txn, we ? "WR" : "RD", addr, wdata, k, hit, ready_n + 1, cpu_rdata,
             hit_count, miss_count);
  endtask

  initial begin
    bit         saw_ready, saw_mreq;
    bit         r_we;
    logic [7:0] r_addr, r_wdata;
    int         r_k;

    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 8'($urandom);
      ref_mem[i] = env_mem[i];
    end
    env_mem[8'h25] = 8'hA7;
    ref_mem[8'h25] = 8'hA7;
    model_reset();

    // Power-on reset.
    do_reset();

    // Read miss then hit, conflict eviction, write-through, busy ignore.
    do_txn(1'b0, 8'h25, 8'h00, 2, 1'b0);
    do_txn(1'b0, 8'h25, 8'h00, 0, 1'b0);
    do_txn(1'b0, 8'h15, 8'h00, 1, 1'b0);
    do_txn(1'b0, 8'h25, 8'h00, 0, 1'b0);
    do_txn(1'b1, 8'h3C, 8'h5A, 0, 1'b0);
    do_txn(1'b0, 8'h3C, 8'h00, 0, 1'b0);
    do_txn(1'b0, 8'h47, 8'h00, 3, 1'b1);

    // Reset while in MEM_READ: everything drops immediately, no completion.
    @(negedge clk);
    ack_delay = 40;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 8'h99;
    saw_mreq  = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      if (mem_req) begin
        saw_mreq = 1'b1;
        break;
      end
    end
    check("rst_mreq_seen", {31'd0, saw_mreq}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_idle_outputs("rst_mid");
    saw_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (cpu_ready || mem_req) saw_ready = 1'b1;
    end
    check("rst_no_activity", {31'd0, saw_ready}, 32'd0);
    rst = 1'b1;
    do_txn(1'b0, 8'h25, 8'h00, 1, 1'b0);

    // Saturation: one miss then five hits; hit_count goes 1,2,3,3,3.
    do_reset();
    do_txn(1'b0, 8'h25, 8'h00, 1, 1'b0);
    for (int i = 0; i < 5; i++) do_txn(1'b0, 8'h25, 8'h00, 0, 1'b0);

    // Random traffic over a small address set so hits and conflicts are common.
    for (int t = 0; t < 40; t++) begin
      if (t % 8 == 0) do_reset();
      r_we    = ($urandom_range(0, 3) == 0);
      r_addr  = 8'(($urandom_range(0, 3) << 4) | $urandom_range(0, 3));
      r_wdata = 8'($urandom);
      r_k     = $urandom_range(0, 3);
      do_txn(r_we, r_addr, r_wdata, r_k, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
